// File: rtl/axi4_arb_pkg.sv
// axi4_arb_pkg: shared FSM state type and AXI constants for the IFU/LSU arbiter
package axi4_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IFU = 2'd1,
    RD_LSU = 2'd2,
    WR_LSU = 2'd3
  } arb_state_e;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic       LAST_IFU   = 1'b0;
  localparam logic       LAST_LSU   = 1'b1;
endpackage

// File: rtl/axi4_if.sv
// axi4_if: AXI4 bundle with master/slave modports
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_arb_grant.sv
// axi4_arb_grant: IDLE-time grant selector; AXI4_ARB_RR_EN selects round-robin read ties
module axi4_arb_grant
  import axi4_arb_pkg::*;
(
  input  logic       ifu_arvalid_i,
  input  logic       lsu_arvalid_i,
  input  logic       lsu_awvalid_i,
`ifdef AXI4_ARB_RR_EN
  input  logic       last_rd_i,
`endif
  output arb_state_e next_o
);
  logic lsu_wins_tie;
`ifdef AXI4_ARB_RR_EN
  assign lsu_wins_tie = last_rd_i == LAST_IFU;
`else
  assign lsu_wins_tie = 1'b1;
`endif
  // writes pre-empt reads; a read tie goes to whoever the policy favours
  always_comb
    next_o = lsu_awvalid_i ? WR_LSU :
             (lsu_arvalid_i && (!ifu_arvalid_i || lsu_wins_tie)) ? RD_LSU :
             ifu_arvalid_i ? RD_IFU : IDLE;
endmodule

// File: rtl/axi4_arbiter.sv
// axi4_arbiter: IFU/LSU to single AXI4 port, one transaction at a time (AXI4_ARB_RR_EN: round-robin read ties)
module axi4_arbiter
  import axi4_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  axi4_if.slave  ifu_s,
  axi4_if.slave  lsu_s,
  axi4_if.master mem_m
);
  arb_state_e state_q, state_d;
  logic ar_done_q, aw_done_q, w_done_q;
  logic rd_ifu, rd_lsu, wr_lsu;
  assign rd_ifu = state_q == RD_IFU;
  assign rd_lsu = state_q == RD_LSU;
  assign wr_lsu = state_q == WR_LSU;
`ifdef AXI4_ARB_RR_EN
  logic last_rd_q;
`endif
  axi4_arb_grant u_grant (
    .ifu_arvalid_i(ifu_s.arvalid),
    .lsu_arvalid_i(lsu_s.arvalid),
    .lsu_awvalid_i(lsu_s.awvalid),
`ifdef AXI4_ARB_RR_EN
    .last_rd_i    (last_rd_q),
`endif
    .next_o       (state_d)
  );
  // grant in IDLE, hold until the final R beat or the B handshake; done flags stop repeat forwarding
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= state_d;
        RD_IFU, RD_LSU: begin
          if (mem_m.arvalid && mem_m.arready) ar_done_q <= 1'b1;
          if (mem_m.rvalid && mem_m.rready && mem_m.rlast) begin
            state_q   <= IDLE;
            ar_done_q <= 1'b0;
          end
        end
        WR_LSU: begin
          if (mem_m.awvalid && mem_m.awready) aw_done_q <= 1'b1;
          if (mem_m.wvalid && mem_m.wready && mem_m.wlast) w_done_q <= 1'b1;
          if (mem_m.bvalid && mem_m.bready) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
      endcase
    end
`ifdef AXI4_ARB_RR_EN
  // remember the winner of the last genuine read tie so the other side wins the next one
  always_ff @(posedge clk or posedge rst)
    if (rst) last_rd_q <= LAST_IFU;
    else if (state_q == IDLE && ifu_s.arvalid && lsu_s.arvalid && !lsu_s.awvalid)
      last_rd_q <= (state_d == RD_LSU) ? LAST_LSU : LAST_IFU;
`endif
  assign mem_m.awid    = lsu_s.awid;
  assign mem_m.awaddr  = lsu_s.awaddr;
  assign mem_m.awlen   = lsu_s.awlen;
  assign mem_m.awsize  = lsu_s.awsize;
  assign mem_m.awburst = lsu_s.awburst;
  assign mem_m.awcache = lsu_s.awcache;
  assign mem_m.awprot  = lsu_s.awprot;
  assign mem_m.awvalid = wr_lsu && !aw_done_q && lsu_s.awvalid;
  assign lsu_s.awready = wr_lsu && !aw_done_q && mem_m.awready;
  assign mem_m.wdata   = lsu_s.wdata;
  assign mem_m.wstrb   = lsu_s.wstrb;
  assign mem_m.wlast   = lsu_s.wlast;
  assign mem_m.wvalid  = wr_lsu && !w_done_q && lsu_s.wvalid;
  assign lsu_s.wready  = wr_lsu && !w_done_q && mem_m.wready;
  assign lsu_s.bvalid  = wr_lsu && mem_m.bvalid;
  assign lsu_s.bresp   = wr_lsu ? mem_m.bresp : RESP_OKAY;
  assign lsu_s.bid     = wr_lsu ? mem_m.bid : '0;
  assign mem_m.bready  = wr_lsu && lsu_s.bready;
  assign ifu_s.awready = 1'b0;
  assign ifu_s.wready  = 1'b0;
  assign ifu_s.bvalid  = 1'b0;
  assign ifu_s.bresp   = RESP_OKAY;
  assign ifu_s.bid     = '0;
  assign mem_m.arid    = rd_ifu ? ifu_s.arid    : lsu_s.arid;
  assign mem_m.araddr  = rd_ifu ? ifu_s.araddr  : lsu_s.araddr;
  assign mem_m.arlen   = rd_ifu ? ifu_s.arlen   : lsu_s.arlen;
  assign mem_m.arsize  = rd_ifu ? ifu_s.arsize  : lsu_s.arsize;
  assign mem_m.arburst = rd_ifu ? ifu_s.arburst : lsu_s.arburst;
  assign mem_m.arcache = rd_ifu ? ifu_s.arcache : lsu_s.arcache;
  assign mem_m.arprot  = rd_ifu ? ifu_s.arprot  : lsu_s.arprot;
  assign mem_m.arvalid = !ar_done_q && (rd_ifu ? ifu_s.arvalid : rd_lsu && lsu_s.arvalid);
  assign ifu_s.arready = rd_ifu && !ar_done_q && mem_m.arready;
  assign lsu_s.arready = rd_lsu && !ar_done_q && mem_m.arready;
  assign mem_m.rready  = rd_ifu ? ifu_s.rready : rd_lsu && lsu_s.rready;
  assign ifu_s.rvalid  = rd_ifu && mem_m.rvalid;
  assign ifu_s.rlast   = rd_ifu && mem_m.rlast;
  assign ifu_s.rdata   = rd_ifu ? mem_m.rdata : '0;
  assign ifu_s.rresp   = rd_ifu ? mem_m.rresp : RESP_OKAY;
  assign ifu_s.rid     = rd_ifu ? mem_m.rid : '0;
  assign lsu_s.rvalid  = rd_lsu && mem_m.rvalid;
  assign lsu_s.rlast   = rd_lsu && mem_m.rlast;
  assign lsu_s.rdata   = rd_lsu ? mem_m.rdata : '0;
  assign lsu_s.rresp   = rd_lsu ? mem_m.rresp : RESP_OKAY;
  assign lsu_s.rid     = rd_lsu ? mem_m.rid : '0;
endmodule

// File: tb/tb_axi4_arbiter.sv
// tb_axi4_arbiter: scoreboard bench for axi4_arbiter with a simple AXI memory model
module tb_axi4_arbiter;
  import axi4_arb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  axi4_if ifu_if ();
  axi4_if lsu_if ();
  axi4_if mem_if ();
  axi4_arbiter dut (.clk(clk), .rst(rst), .ifu_s(ifu_if), .lsu_s(lsu_if), .mem_m(mem_if));
  typedef struct packed {logic id; logic last; logic [31:0] data;} rbeat_t;
  typedef struct packed {logic [31:0] addr; logic [31:0] bcnt;} ar_t;
  rbeat_t ifu_q[$];
  rbeat_t lsu_q[$];
  ar_t ar_q[$];
  logic [2:0] b_q[$];
  int tests = 0;
  int fails = 0;
  int b_cnt = 0;
  bit lsu_rv_seen = 0;
  bit ifu_bv_seen = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  logic rd_busy = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [7:0] rd_len = '0, rd_beat = '0;
  logic rd_id = 1'b0, b_id = 1'b0, aw_got = 1'b0, w_got = 1'b0;
  bit aw_hold = 0;
  int aw_cnt = 0, w_cnt = 0;
  logic [31:0] last_aw = '0, last_wd = '0;
  assign mem_if.arready = !rd_busy;
  assign mem_if.rvalid  = rd_busy;
  assign mem_if.rdata   = rd_addr + 32'(rd_beat);
  assign mem_if.rlast   = rd_beat == rd_len;
  assign mem_if.rid     = rd_id;
  assign mem_if.rresp   = RESP_OKAY;
  assign mem_if.awready = !aw_hold;
  assign mem_if.wready  = 1'b1;
  assign mem_if.bvalid  = aw_got && w_got;
  assign mem_if.bresp   = RESP_OKAY;
  assign mem_if.bid     = b_id;
  always @(posedge clk or posedge rst)
    if (rst) begin
      rd_busy <= 1'b0;
      rd_beat <= '0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
    end else begin
      if (mem_if.arvalid && mem_if.arready) begin
        rd_busy <= 1'b1;
        rd_addr <= mem_if.araddr;
        rd_len  <= mem_if.arlen;
        rd_beat <= '0;
        rd_id   <= mem_if.arid;
      end else if (mem_if.rvalid && mem_if.rready) begin
        if (mem_if.rlast) rd_busy <= 1'b0;
        else rd_beat <= rd_beat + 8'd1;
      end
      if (mem_if.awvalid && mem_if.awready) begin
        aw_got  <= 1'b1;
        b_id    <= mem_if.awid;
        aw_cnt  <= aw_cnt + 1;
        last_aw <= mem_if.awaddr;
      end
      if (mem_if.wvalid && mem_if.wready) begin
        w_cnt   <= w_cnt + 1;
        last_wd <= mem_if.wdata;
        if (mem_if.wlast) w_got <= 1'b1;
      end
      if (mem_if.bvalid && mem_if.bready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  always @(negedge clk) begin
    rbeat_t e;
    ar_t a;
    if (lsu_if.rvalid) lsu_rv_seen = 1;
    if (ifu_if.bvalid) ifu_bv_seen = 1;
    if (ifu_if.rvalid && ifu_if.rready) begin
      if (ifu_q.size() == 0) check("ifu_r_unexpected", ifu_if.rvalid, 0);
      else begin
        e = ifu_q.pop_front();
        check("ifu_r", {ifu_if.rid, ifu_if.rlast, ifu_if.rdata}, e);
      end
    end
    if (lsu_if.rvalid && lsu_if.rready) begin
      if (lsu_q.size() == 0) check("lsu_r_unexpected", lsu_if.rvalid, 0);
      else begin
        e = lsu_q.pop_front();
        check("lsu_r", {lsu_if.rid, lsu_if.rlast, lsu_if.rdata}, e);
      end
    end
    if (mem_if.arvalid && mem_if.arready) begin
      if (ar_q.size() == 0) check("mem_ar_unexpected", mem_if.arvalid, 0);
      else begin
        a = ar_q.pop_front();
        check("mem_ar_order", {mem_if.araddr, 32'(b_cnt)}, a);
      end
    end
    if (lsu_if.bvalid && lsu_if.bready) begin
      b_cnt++;
      if (b_q.size() == 0) check("lsu_b_unexpected", lsu_if.bvalid, 0);
      else check("lsu_b", {lsu_if.bid, lsu_if.bresp}, b_q.pop_front());
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic exp_ar(input logic [31:0] a, input int bc);
    ar_q.push_back({a, 32'(bc)});
  endtask
  task automatic rd(input bit from_lsu, input logic [31:0] a, input logic [7:0] len);
    bit ok = 0;
    for (int i = 0; i <= int'(len); i++) begin
      rbeat_t e = {from_lsu, i == int'(len), a + 32'(i)};
      if (from_lsu) lsu_q.push_back(e);
      else ifu_q.push_back(e);
    end
    if (from_lsu) begin
      lsu_if.araddr = a; lsu_if.arlen = len; lsu_if.arid = 1'b1; lsu_if.arvalid = 1'b1;
    end else begin
      ifu_if.araddr = a; ifu_if.arlen = len; ifu_if.arid = 1'b0; ifu_if.arvalid = 1'b1;
    end
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = from_lsu ? (lsu_if.arvalid && lsu_if.arready) : (ifu_if.arvalid && ifu_if.arready);
      @(posedge clk);
      #1;
    end
    if (from_lsu) lsu_if.arvalid = 1'b0;
    else ifu_if.arvalid = 1'b0;
    if (!ok) check("ar_timeout", ok, 1);
  endtask
  task automatic wr(input logic [31:0] a, input int w_lead);
    bit ok = 0;
    b_q.push_back({1'b1, RESP_OKAY});
    lsu_if.wdata = a ^ 32'hA5A5_0000; lsu_if.wstrb = '1; lsu_if.wlast = 1'b1; lsu_if.wvalid = 1'b1;
    if (w_lead > 0) tick(w_lead);
    lsu_if.awaddr = a; lsu_if.awlen = 8'd0; lsu_if.awid = 1'b1; lsu_if.awburst = BURST_INCR;
    lsu_if.awvalid = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = lsu_if.bvalid && lsu_if.bready;
      @(posedge clk);
      #1;
    end
    lsu_if.awvalid = 1'b0;
    lsu_if.wvalid  = 1'b0;
    if (!ok) check("b_timeout", ok, 1);
  endtask
  task automatic drain();
    for (int c = 0; c < 300 && (ifu_q.size() + lsu_q.size() + b_q.size() + ar_q.size()) != 0; c++) tick();
    check("drain", 64'(ifu_q.size() + lsu_q.size() + b_q.size() + ar_q.size()), 0);
    tick(2);
  endtask
  task automatic chk_zero(input string name);
    check({name, "_mem"}, {mem_if.arvalid, mem_if.rready, mem_if.awvalid, mem_if.wvalid, mem_if.bready}, 0);
    check({name, "_up"}, {ifu_if.arready, ifu_if.rvalid, ifu_if.rdata, ifu_if.rresp, ifu_if.rid,
                          lsu_if.arready, lsu_if.awready, lsu_if.wready, lsu_if.rvalid, lsu_if.bvalid,
                          ifu_if.awready, ifu_if.wready, ifu_if.bvalid}, 0);
    check({name, "_rsp"}, {lsu_if.rdata, lsu_if.rresp, lsu_if.rid, lsu_if.bresp, lsu_if.bid, ifu_if.bresp, ifu_if.bid}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bit seen;
    bit lsu_first;
    int a0, w0;
    {ifu_if.awid, ifu_if.awaddr, ifu_if.awlen, ifu_if.awsize, ifu_if.awburst, ifu_if.awcache, ifu_if.awprot, ifu_if.awvalid} = '0;
    {ifu_if.wdata, ifu_if.wstrb, ifu_if.wlast, ifu_if.wvalid, ifu_if.bready} = '0;
    {ifu_if.arid, ifu_if.araddr, ifu_if.arlen, ifu_if.arsize, ifu_if.arcache, ifu_if.arprot, ifu_if.arvalid} = '0;
    {lsu_if.awid, lsu_if.awaddr, lsu_if.awlen, lsu_if.awsize, lsu_if.awcache, lsu_if.awprot, lsu_if.awvalid} = '0;
    {lsu_if.wdata, lsu_if.wstrb, lsu_if.wlast, lsu_if.wvalid} = '0;
    {lsu_if.arid, lsu_if.araddr, lsu_if.arlen, lsu_if.arsize, lsu_if.arcache, lsu_if.arprot, lsu_if.arvalid} = '0;
    ifu_if.arburst = BURST_INCR; lsu_if.arburst = BURST_INCR; lsu_if.awburst = BURST_INCR;
    ifu_if.rready = 1'b1; lsu_if.rready = 1'b1; lsu_if.bready = 1'b1;
    tick(3);
    chk_zero("reset");
    check("reset_state", dut.state_q, IDLE);
    rst = 1'b0;
    tick(2);
    lsu_rv_seen = 0;
    exp_ar(32'h1000, 0);
    rd(1'b0, 32'h1000, 8'd3);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = ifu_if.rvalid && ifu_if.rready && ifu_if.rlast;
      if (seen) check("state_on_last", dut.state_q, RD_IFU);
      @(posedge clk);
      #1;
    end
    check("last_beat_seen", seen, 1);
    @(negedge clk);
    check("state_after_last", dut.state_q, IDLE);
    drain();
    check("lsu_rvalid_during_ifu", lsu_rv_seen, 0);
    for (int r = 0; r < 3; r++) begin
`ifdef AXI4_ARB_RR_EN
      lsu_first = r != 1;
`else
      lsu_first = 1;
`endif
      if (lsu_first) begin
        exp_ar(32'h2100 + 32'(r * 16), 0);
        exp_ar(32'h1100 + 32'(r * 16), 0);
      end else begin
        exp_ar(32'h1100 + 32'(r * 16), 0);
        exp_ar(32'h2100 + 32'(r * 16), 0);
      end
      fork
        rd(1'b0, 32'h1100 + 32'(r * 16), 8'd0);
        rd(1'b1, 32'h2100 + 32'(r * 16), 8'd0);
      join
      drain();
    end
    aw_hold = 1;
    a0 = aw_cnt;
    w0 = w_cnt;
    fork
      wr(32'h3000, 2);
      begin
        tick(6);
        aw_hold = 0;
      end
    join
    drain();
    check("aw_beats", 64'(aw_cnt - a0), 1);
    check("w_beats", 64'(w_cnt - w0), 1);
    check("aw_addr", last_aw, 32'h3000);
    check("w_data", last_wd, 32'hA5A5_3000);
    check("ifu_bvalid_seen", ifu_bv_seen, 0);
    exp_ar(32'h2800, 2);
    fork
      wr(32'h3800, 0);
      rd(1'b1, 32'h2800, 8'd0);
    join
    drain();
    ifu_if.rready = 1'b0;
    exp_ar(32'h4000, 2);
    rd(1'b0, 32'h4000, 8'd1);
    for (int c = 0; c < 20 && !mem_if.rvalid; c++) tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold", {mem_if.rvalid, mem_if.rready, ifu_if.rvalid, ifu_if.rdata}, {1'b1, 1'b0, 1'b1, 32'h4000});
      check("bp_state", dut.state_q, RD_IFU);
      @(posedge clk);
      #1;
    end
    ifu_if.rready = 1'b1;
    drain();
    exp_ar(32'h5000, 2);
    rd(1'b0, 32'h5000, 8'd3);
    for (int c = 0; c < 50 && ifu_q.size() > 3; c++) tick();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    check("midrst_state", dut.state_q, IDLE);
    ifu_q.delete();
    tick(2);
    rst = 1'b0;
    lsu_q.push_back({1'b1, 1'b1, 32'h6000});
    exp_ar(32'h6000, 2);
    lsu_if.araddr = 32'h6000; lsu_if.arlen = 8'd0; lsu_if.arid = 1'b1; lsu_if.arvalid = 1'b1;
    @(negedge clk);
    check("post_rst_bubble", mem_if.arvalid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_grant", {mem_if.arvalid, mem_if.araddr}, {1'b1, 32'h6000});
    @(posedge clk);
    #1;
    lsu_if.arvalid = 1'b0;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi4_arbiter.md
# axi4_arbiter

Two-master to one-slave AXI4 arbiter in front of the CPU's single memory/bus port. It shares the port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write). Exactly one transaction is outstanding at a time. Each grant holds until that transaction's final response handshake, so bursts are never interleaved.

## Interface
- ADDR_WIDTH, 32, address width of all three `axi4_if` ports
- DATA_WIDTH, 32, data width of all three ports
- ID_WIDTH, 1, ID width of all three ports; IDs pass through unchanged

- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- ifu_s  axi4_if.slave  bundle  IFU-facing port; only read channels are used
- lsu_s  axi4_if.slave  bundle  LSU-facing port; read and write channels
- mem_m  axi4_if.master  bundle  downstream port to crossbar/memory

## Operation
- FSM states: IDLE, RD_IFU, RD_LSU, WR_LSU, held in a registered `state`.
- Arbitration is evaluated only in IDLE, one cycle after the valids are sampled.
  - If `lsu_s.awvalid` → WR_LSU.
  - Else, with a read contention, the grant follows the Configuration policy.
  - Else a lone `arvalid` → the matching RD_* state.
  - Else stay in IDLE.
- LSU write beats LSU read when both are requested in the same cycle.
- RD_x (x = IFU or LSU):
  - AR and R channels of x are wired straight to `mem_m`.
  - The other requester sees `arready=0` and `rvalid=0`.
  - Leave to IDLE on `mem_m.rvalid && rready && rlast`.
- WR_LSU:
  - `lsu_s` AW, W and B are wired straight to `mem_m`.
  - AW and W may complete in either order. Sticky flags `aw_done` and `w_done` (w_done set on the wlast beat) block any repeat forwarding.
  - Leave to IDLE on `mem_m.bvalid && bready`; both flags clear at that point.
- Fixed tie-offs for ungranted or unused channels:
  - IFU write channels: `awready=0`, `wready=0`, `bvalid=0`, `bresp=0`, `bid=0`.
  - Ungranted `mem_m` request valids are 0; `mem_m.rready`/`bready` are 0 outside their owning state.
- rresp and bresp pass through unmodified; the arbiter does no error handling.
- Reset mid-transaction: state → IDLE and flags clear immediately. An in-flight burst is abandoned; the downstream slave shares the same `rst`.

## Timing
- Reset values:
  - All `mem_m` valids and readies are 0.
  - All upstream `arready`, `awready`, `wready`, `rvalid` and `bvalid` are 0.
  - rdata, rresp, rid, bresp and bid are driven 0.
- Grant latency: a request first visible in IDLE at cycle N is forwarded to `mem_m` at cycle N+1. This is one bubble per transaction.
- Forwarding within a granted state is combinational, so upstream sees the downstream ready/valid in the same cycle.
- Requesters must hold valid and payload until handshake (AXI rule). The arbiter never withdraws a forwarded valid.
- Back-to-back transactions: the final response handshake at cycle M puts the FSM in IDLE at M+1. The next forward is at M+2 at the earliest.
- Burst length is limited only by the downstream slave. The grant is held for all arlen+1 beats.

## Configuration
- `AXI4_ARB_RR_EN` defined: round-robin between IFU and LSU reads on simultaneous `arvalid`.
  - A one-bit `last_rd` register records the last read winner; the other requester wins next.
  - `last_rd` resets to IFU, so LSU wins the first tie.
  - Writes still pre-empt reads.
- Not defined: fixed priority, LSU read over IFU read; `last_rd` is not instantiated.

## Structure
- Package `axi4_arb_pkg`:
  - `arb_state_e` enum (IDLE, RD_IFU, RD_LSU, WR_LSU).
  - AXI constants: `BURST_INCR=2'b01`, `RESP_OKAY=2'b00`.
- Sub-module `axi4_arb_grant`: pure IDLE-time grant selector. Inputs are the three valids plus `last_rd`; output is the next state. This isolates the `AXI4_ARB_RR_EN` logic.
- The top module holds the FSM, the aw/w flags and the channel muxes.

## Test plan
- Lone IFU read, arlen=3: 4 beats returned to IFU in order, rlast on beat 4; LSU sees no rvalid; FSM back in IDLE the cycle after the last beat.
- Simultaneous IFU and LSU reads, arlen=0, three rounds:
  - Fixed mode: LSU, LSU, LSU each time, with IFU served after each.
  - `AXI4_ARB_RR_EN`: LSU, IFU, LSU alternates on every tie.
- LSU write, W before AW (wvalid two cycles early, wlast=1), then bresp=OKAY: exactly one AW and one W beat reach `mem_m`; bvalid reaches LSU; IFU bvalid stays 0.
- LSU awvalid and arvalid in the same IDLE cycle: write completes (B handshake) before the read's arvalid is forwarded.
- Reset asserted during beat 2 of a 4-beat IFU burst: all outputs drop to 0 asynchronously; after release, a fresh LSU read is granted in one cycle.
- Downstream rready backpressure (mem rvalid held, IFU rready low for 3 cycles): beat not lost; grant retained; no state change.
